// File: rtl/memwb_stage_if.sv
// memwb_stage_if: MEM-side ready/valid entry bus and WB-side writeback bus of the MEM/WB stage.
interface memwb_stage_if #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_memory_data;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic              out_wb_en;
  logic [DEST_W-1:0] out_dest;
  logic [DATA_W-1:0] out_wb_data;
  logic [DATA_W-1:0] out_pc;
  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_alu_result, in_memory_data, in_dest, in_pc, out_ready,
    input  in_ready, out_valid, out_wb_en, out_dest, out_wb_data, out_pc
  );
  modport slave (
    input  in_valid, in_wb_en, in_mem_r_en, in_alu_result, in_memory_data, in_dest, in_pc, out_ready,
    output in_ready, out_valid, out_wb_en, out_dest, out_wb_data, out_pc
  );
endinterface

// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB pipeline stage with ready/valid handshake and a 2-entry skid buffer.
// Define MEMWB_STALL_CNT_EN to build the saturating stall counter; otherwise stall_cnt is tied to 0.
module memwb_stage #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  memwb_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic              wb_en;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } ent_t;
  state_t state_q, state_d;
  ent_t   head_q, head_d, skid_q, skid_d, in_ent;
  logic   rdy_q, vld, acc, ret;
  // writeback data is selected on capture, so only one data word is stored per entry
  assign in_ent = '{wb_en: bus.in_wb_en, dest: bus.in_dest,
                    data: bus.in_mem_r_en ? bus.in_memory_data : bus.in_alu_result, pc: bus.in_pc};
  assign vld = state_q != EMPTY;
  assign acc = bus.in_valid & rdy_q;
  assign ret = vld & bus.out_ready;
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        head_d  = in_ent;
      end
      ONE: if (acc & ret) head_d = in_ent;
      else if (acc) begin
        state_d = TWO;
        skid_d  = in_ent;
      end else if (ret) state_d = EMPTY;
      TWO: if (ret) begin
        state_d = ONE;
        head_d  = skid_q;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= state_d != TWO;
    end
  end
  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = vld;
  assign bus.out_wb_en   = vld & head_q.wb_en;
  assign bus.out_dest    = head_q.dest;
  assign bus.out_wb_data = head_q.data;
  assign bus.out_pc      = head_q.pc;
`ifdef MEMWB_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else if (vld & ~bus.out_ready & ~&cnt_q) cnt_q <= cnt_q + 1'b1;
  end
  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif
endmodule
